// File: rtl/tl_ram.sv
// TileLink scratch RAM responder: single-ported synchronous array serving Get/Put
// bursts one transaction at a time, with error responses for bad size or alignment.
module tl_ram #(
    parameter int DEPTH      = 512,
    parameter int BEAT_BYTES = 8,
    parameter int MAX_SIZE   = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_valid_i,
    output logic        a_ready_o,
    input  logic [2:0]  a_opcode_i,
    input  logic [2:0]  a_size_i,
    input  logic [3:0]  a_source_i,
    input  logic [63:0] a_address_i,
    input  logic [BEAT_BYTES-1:0] a_mask_i,
    input  logic [BEAT_BYTES*8-1:0] a_data_i,
    output logic        d_valid_o,
    input  logic        d_ready_i,
    output logic [2:0]  d_opcode_o,
    output logic [2:0]  d_size_o,
    output logic [3:0]  d_source_o,
    output logic [BEAT_BYTES*8-1:0] d_data_o,
    output logic        d_error_o
);
    localparam int IW = $clog2(DEPTH);
    localparam int DW = BEAT_BYTES * 8;

    typedef enum logic [1:0] {IDLE, RD, WR, ACK} state_e;

    state_e          state_q, state_d;
    logic            rdy_q;
    logic [3:0]      src_q, src_d;
    logic [2:0]      size_q, size_d;
    logic [IW-1:0]   base_q, base_d;
    logic [4:0]      len_q, len_d;
    logic [4:0]      beat_q, beat_d;
    logic            err_q, err_d;
    logic [DW-1:0]   data_q;

    logic [DW-1:0]   mem [DEPTH];

    logic            a_fire, d_fire, req_err, last;
    logic [63:0]     amask;
    logic [4:0]      req_len;
    logic [IW-1:0]   a_idx;
    logic            rd_en, rd_zero, wr_en;
    logic [IW-1:0]   raddr, waddr;

    // Aligned-burst wrap: the low bits of the index roll over within the burst.
    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base,
                                               input logic [4:0] len,
                                               input logic [4:0] k);
        logic [IW-1:0] lm;
        lm = IW'(len - 5'd1);
        return (base & ~lm) | ((base + IW'(k)) & lm);
    endfunction

    assign a_ready_o  = rdy_q && (state_q == IDLE || state_q == WR);
    assign d_valid_o  = (state_q == RD) || (state_q == ACK);
    assign d_opcode_o = (state_q == RD) ? 3'd1 : 3'd0;
    assign d_size_o   = size_q;
    assign d_source_o = src_q;
    assign d_error_o  = err_q;
    assign d_data_o   = data_q;

    assign a_fire  = a_valid_i && a_ready_o;
    assign d_fire  = d_valid_o && d_ready_i;
    assign amask   = (64'd1 << a_size_i) - 64'd1;
    assign req_err = (a_size_i > 3'(MAX_SIZE)) || (|(a_address_i & amask));
    assign req_len = (a_size_i <= 3'd3) ? 5'd1 : (5'd1 << (a_size_i - 3'd3));
    assign a_idx   = a_address_i[IW+2:3];
    assign last    = (beat_q == len_q - 5'd1);

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        size_d  = size_q;
        base_d  = base_q;
        len_d   = len_q;
        beat_d  = beat_q;
        err_d   = err_q;
        rd_en   = 1'b0;
        rd_zero = 1'b0;
        raddr   = a_idx;
        wr_en   = 1'b0;
        waddr   = a_idx;
        unique case (state_q)
            IDLE: begin
                if (a_fire) begin
                    src_d  = a_source_i;
                    size_d = a_size_i;
                    base_d = a_idx;
                    len_d  = req_len;
                    err_d  = req_err;
                    if (a_opcode_i == 3'd4) begin
                        rd_en   = 1'b1;
                        rd_zero = req_err;
                        beat_d  = 5'd0;
                        state_d = RD;
                    end else if (a_opcode_i == 3'd0 || a_opcode_i == 3'd1) begin
                        wr_en   = !req_err;
                        beat_d  = 5'd1;
                        state_d = (req_len == 5'd1) ? ACK : WR;
                    end else begin
                        err_d   = 1'b1;
                        len_d   = 5'd1;
                        state_d = ACK;
                    end
                end
            end
            RD: begin
                if (d_fire) begin
                    if (last) begin
                        state_d = IDLE;
                    end else begin
                        // Issue next word's read on this fire so beats stream with no bubble.
                        rd_en   = 1'b1;
                        rd_zero = err_q;
                        raddr   = wrap_idx(base_q, len_q, beat_q + 5'd1);
                        beat_d  = beat_q + 5'd1;
                    end
                end
            end
            WR: begin
                waddr = wrap_idx(base_q, len_q, beat_q);
                if (a_fire) begin
                    wr_en = !err_q;
                    if (last) state_d = ACK;
                    else      beat_d  = beat_q + 5'd1;
                end
            end
            ACK: begin
                if (d_fire) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rdy_q   <= 1'b0;
            src_q   <= '0;
            size_q  <= '0;
            base_q  <= '0;
            len_q   <= 5'd1;
            beat_q  <= '0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
            src_q   <= src_d;
            size_q  <= size_d;
            base_q  <= base_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
            if (rd_en) data_q <= rd_zero ? '0 : mem[raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < BEAT_BYTES; b++) begin
                if (a_mask_i[b]) mem[waddr][8*b +: 8] <= a_data_i[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_tl_ram.sv
// Scoreboard bench for tl_ram: expected D beats are queued as requests are driven
// and compared by a negedge monitor as each D beat fires.
module tb_tl_ram;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_valid = 1'b0, a_ready;
    logic [2:0]  a_opcode = '0, a_size = '0;
    logic [3:0]  a_source = '0;
    logic [63:0] a_address = '0;
    logic [7:0]  a_mask = '0;
    logic [63:0] a_data = '0;
    logic        d_valid, d_ready = 1'b1;
    logic [2:0]  d_opcode, d_size;
    logic [3:0]  d_source;
    logic [63:0] d_data;
    logic        d_error;

    always #5 clk = ~clk;

    tl_ram #(.DEPTH(512), .BEAT_BYTES(8), .MAX_SIZE(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid_i(a_valid), .a_ready_o(a_ready), .a_opcode_i(a_opcode),
        .a_size_i(a_size), .a_source_i(a_source), .a_address_i(a_address),
        .a_mask_i(a_mask), .a_data_i(a_data),
        .d_valid_o(d_valid), .d_ready_i(d_ready), .d_opcode_o(d_opcode),
        .d_size_o(d_size), .d_source_o(d_source), .d_data_o(d_data), .d_error_o(d_error)
    );

    typedef struct packed {
        logic [2:0]  op;
        logic [2:0]  size;
        logic [3:0]  src;
        logic [63:0] data;
        logic        err;
    } beat_t;

    beat_t sb[$];
    int    checks = 0, failures = 0, fires = 0;
    logic  held = 1'b0;
    beat_t held_v;

    always @(posedge clk) if (rst_n && d_valid && d_ready) fires++;

    always @(negedge clk) begin
        beat_t got, exp;
        got = '{op: d_opcode, size: d_size, src: d_source, data: d_data, err: d_error};
        if (held && d_valid) begin
            checks++;
            if (got !== held_v) begin
                failures++;
                $display("FAIL stall_hold got=%h required=%h", got, held_v);
            end
        end
        held = 1'b0;
        if (d_valid && !d_ready) begin
            held   = 1'b1;
            held_v = got;
        end
        if (d_valid && d_ready) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL d_unexpected got op=%0d data=%h", d_opcode, d_data);
            end else begin
                exp = sb.pop_front();
                if (exp.op == 3'd0) got.data = exp.data;  // AccessAck carries no data
                if (got !== exp) begin
                    failures++;
                    $display("FAIL d_beat got op=%0d size=%0d src=%0d data=%h err=%b required op=%0d size=%0d src=%0d data=%h err=%b",
                             got.op, got.size, got.src, got.data, got.err,
                             exp.op, exp.size, exp.src, exp.data, exp.err);
                end
            end
        end
    end

    task automatic push(input logic [2:0] op, input logic [2:0] sz, input logic [3:0] src,
                        input logic [63:0] data, input logic err);
        sb.push_back('{op: op, size: sz, src: src, data: data, err: err});
    endtask

    task automatic a_send(input logic [2:0] op, input logic [2:0] sz, input logic [3:0] src,
                          input logic [63:0] addr, input logic [7:0] mask, input logic [63:0] data);
        int n = 0;
        a_valid = 1'b1; a_opcode = op; a_size = sz; a_source = src;
        a_address = addr; a_mask = mask; a_data = data;
        @(negedge clk);
        while (!a_ready && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (!a_ready) begin
            failures++;
            $display("FAIL a_accept_timeout a_ready=%b required=1", a_ready);
        end
        @(posedge clk); #1;
        a_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin @(negedge clk); n++; end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d required=0", sb.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({a_ready, d_valid, d_opcode, d_size, d_source, d_data, d_error} !== '0) begin
            failures++;
            $display("FAIL reset_outputs a_ready=%b d_valid=%b d_data=%h required all zero", a_ready, d_valid, d_data);
        end
        @(negedge clk); rst_n = 1'b1; #1;
        checks++;
        if (a_ready !== 1'b0) begin failures++; $display("FAIL ready_before_edge got=%b required=0", a_ready); end
        @(posedge clk); #1;
        checks++;
        if (a_ready !== 1'b1) begin failures++; $display("FAIL ready_after_edge got=%b required=1", a_ready); end
    endtask

    task automatic test_single();
        push(3'd0, 3'd3, 4'd2, 64'd0, 1'b0);
        a_send(3'd0, 3'd3, 4'd2, 64'h40, 8'hFF, 64'h1122334455667788);
        @(negedge clk);
        checks++;
        if (!(d_valid === 1'b1 && d_opcode === 3'd0)) begin
            failures++; $display("FAIL put_latency d_valid=%b op=%0d required 1/0", d_valid, d_opcode);
        end
        wait_drain();
        push(3'd1, 3'd3, 4'd5, 64'h1122334455667788, 1'b0);
        a_send(3'd4, 3'd3, 4'd5, 64'h40, 8'h00, 64'd0);
        @(negedge clk);
        checks++;
        if (!(d_valid === 1'b1 && d_opcode === 3'd1)) begin
            failures++; $display("FAIL get_latency d_valid=%b op=%0d required 1/1", d_valid, d_opcode);
        end
        wait_drain();
    endtask

    task automatic test_partial();
        push(3'd0, 3'd3, 4'd1, 64'd0, 1'b0);
        a_send(3'd1, 3'd3, 4'd1, 64'h40, 8'h0F, 64'hAAAAAAAABBBBBBBB);
        wait_drain();
        push(3'd1, 3'd3, 4'd1, 64'h11223344BBBBBBBB, 1'b0);
        a_send(3'd4, 3'd3, 4'd1, 64'h40, 8'h00, 64'd0);
        wait_drain();
    endtask

    task automatic test_burst();
        push(3'd0, 3'd6, 4'd3, 64'd0, 1'b0);
        for (int k = 0; k < 8; k++) a_send(3'd0, 3'd6, 4'd3, 64'h100 + 64'(8*k), 8'hFF, 64'(k));
        wait_drain();
        for (int k = 0; k < 8; k++) push(3'd1, 3'd6, 4'd4, 64'(k), 1'b0);
        a_send(3'd4, 3'd6, 4'd4, 64'h100, 8'h00, 64'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (d_valid !== 1'b1) begin failures++; $display("FAIL burst_gap beat=%0d d_valid=%b required=1", k, d_valid); end
        end
        wait_drain();
        checks++;
        if (!(a_ready === 1'b1 && d_valid === 1'b0)) begin
            failures++; $display("FAIL burst_idle a_ready=%b d_valid=%b required 1/0", a_ready, d_valid);
        end
    endtask

    task automatic test_backpressure();
        bit pat [7] = '{1, 0, 0, 1, 0, 1, 1};
        int start;
        for (int k = 0; k < 4; k++) push(3'd1, 3'd5, 4'd6, 64'(k), 1'b0);
        a_send(3'd4, 3'd5, 4'd6, 64'h100, 8'h00, 64'd0);
        start = fires;
        for (int i = 0; i < 7; i++) begin
            d_ready = pat[i];
            @(posedge clk); #1;
        end
        d_ready = 1'b1;
        checks++;
        if (fires - start != 4 || sb.size() != 0 || d_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_beats fired=%0d pending=%0d d_valid=%b required 4/0/0", fires - start, sb.size(), d_valid);
        end
        wait_drain();
    endtask

    task automatic test_errors();
        for (int k = 0; k < 16; k++) push(3'd1, 3'd7, 4'd7, 64'd0, 1'b1);
        a_send(3'd4, 3'd7, 4'd7, 64'h0, 8'h00, 64'd0);
        wait_drain();
        push(3'd0, 3'd4, 4'd8, 64'd0, 1'b1);
        a_send(3'd0, 3'd4, 4'd8, 64'h108, 8'hFF, 64'hFFFFFFFFFFFFFFFF);
        a_send(3'd0, 3'd4, 4'd8, 64'h110, 8'hFF, 64'hFFFFFFFFFFFFFFFF);
        wait_drain();
        push(3'd1, 3'd4, 4'd8, 64'd0, 1'b0);
        push(3'd1, 3'd4, 4'd8, 64'd1, 1'b0);
        a_send(3'd4, 3'd4, 4'd8, 64'h100, 8'h00, 64'd0);
        wait_drain();
        push(3'd0, 3'd3, 4'd9, 64'd0, 1'b1);
        a_send(3'd5, 3'd3, 4'd9, 64'h40, 8'hFF, 64'hDEAD);
        wait_drain();
        push(3'd1, 3'd3, 4'd9, 64'h11223344BBBBBBBB, 1'b0);
        a_send(3'd4, 3'd3, 4'd9, 64'h40, 8'h00, 64'd0);
        wait_drain();
    endtask

    task automatic test_reset_mid();
        int start, n = 0;
        for (int k = 0; k < 8; k++) push(3'd1, 3'd6, 4'd10, 64'(k), 1'b0);
        start = fires;
        a_send(3'd4, 3'd6, 4'd10, 64'h100, 8'h00, 64'd0);
        while (fires < start + 3 && n < 50) begin @(negedge clk); n++; end
        rst_n = 1'b0; #1;
        checks++;
        if (!(d_valid === 1'b0 && a_ready === 1'b0)) begin
            failures++; $display("FAIL reset_mid d_valid=%b a_ready=%b required 0/0", d_valid, a_ready);
        end
        sb.delete();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (a_ready !== 1'b1) begin failures++; $display("FAIL reset_release a_ready=%b required=1", a_ready); end
        push(3'd1, 3'd3, 4'd11, 64'h11223344BBBBBBBB, 1'b0);
        a_send(3'd4, 3'd3, 4'd11, 64'h40, 8'h00, 64'd0);
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_partial();
        test_burst();
        test_backpressure();
        test_errors();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end
endmodule
